// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler
// Latches per-floor call buttons, runs SCAN direction control and drives a
// registered target floor into the elevator control unit's request input.
// It watches the control unit's motion/door/floor outputs so that it can
// retire calls and keep the target legal for the unit's move/stop rules.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high; clears all state
//   call_req       call buttons, bit f = floor f (level or pulse)
//   cur_floor      control unit floor output
//   moving_up      control unit up output
//   moving_down    control unit down output
//   door_open      control unit open output
//   target_floor   registered request floor to the control unit
//   pending        latched outstanding calls
//   dir            scan direction: 00 IDLE, 01 UP, 10 DOWN
//   serviced       one-cycle pulse when a call is retired
//   serviced_floor floor retired; valid while serviced is high
module floor_request_scheduler #(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_BITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [FLOOR_BITS-1:0] cur_floor,
   input  logic                  moving_up,
   input  logic                  moving_down,
   input  logic                  door_open,
   output logic [FLOOR_BITS-1:0] target_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [1:0]            dir,
   output logic                  serviced,
   output logic [FLOOR_BITS-1:0] serviced_floor
);

   localparam int FLOOR_SPAN = 1 << FLOOR_BITS;

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_t;

   dir_t                  dir_q;
   dir_t                  dir_next;
   logic                  door_q;
   logic                  door_qq;
   logic [FLOOR_SPAN-1:0] valid_map;
   logic [FLOOR_SPAN-1:0] pend_ext;
   logic                  floor_ok;
   logic                  has_above;
   logic                  has_below;
   logic                  stopped;
   logic                  retire_a;
   logic                  retire_b;
   logic                  retire;
   logic [FLOOR_BITS-1:0] lowest_above;
   logic [FLOOR_BITS-1:0] highest_below;
   logic [FLOOR_BITS-1:0] dist_up;
   logic [FLOOR_BITS-1:0] dist_down;
   logic [FLOOR_BITS-1:0] target_next;
   logic [NUM_FLOORS-1:0] clear_mask;

   // Decode the pending map relative to the car: which floors are served,
   // whether any call lies above/below, and the nearest call on each side.
   // Maps are widened to the full floor-index range so an out-of-range
   // cur_floor indexes a zero bit instead of running off the vector.
   always_comb begin
      valid_map     = '0;
      pend_ext      = '0;
      has_above     = 1'b0;
      has_below     = 1'b0;
      lowest_above  = cur_floor;
      highest_below = cur_floor;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         valid_map[i] = 1'b1;
         pend_ext[i]  = pending[i];
      end
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (i > int'(cur_floor))) begin
            has_above    = 1'b1;
            lowest_above = FLOOR_BITS'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i < int'(cur_floor))) begin
            has_below     = 1'b1;
            highest_below = FLOOR_BITS'(i);
         end
      end
   end

   assign floor_ok  = valid_map[cur_floor];
   assign stopped   = !moving_up && !moving_down;
   assign dist_up   = lowest_above - cur_floor;
   assign dist_down = cur_floor - highest_below;

   // A door opening is detected on the registered door copy, so the call is
   // retired one cycle after the opening is first sampled. A call at the
   // current floor while stopped is retired directly, because the control
   // unit never opens its door for a request equal to the current floor.
   assign retire_a = door_q && !door_qq && floor_ok;
   assign retire_b = stopped && !door_open && floor_ok && pend_ext[cur_floor];
   assign retire   = retire_a || retire_b;

   // Clear mask for the retired floor; applied after the set so a new press
   // of the same floor on the retiring edge is dropped.
   always_comb begin
      clear_mask = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         clear_mask[i] = retire && (i == int'(cur_floor));
      end
   end

   // SCAN direction decision. Frozen while the door is open or the car
   // reports an unserved floor. From IDLE the nearest call wins, ties go UP.
   always_comb begin
      dir_next = dir_q;
      if (!door_open && floor_ok) begin
         case (dir_q)
            DIR_IDLE: begin
               if (has_above && has_below)
                  dir_next = (dist_up <= dist_down) ? DIR_UP : DIR_DOWN;
               else if (has_above)
                  dir_next = DIR_UP;
               else if (has_below)
                  dir_next = DIR_DOWN;
            end
            DIR_UP: begin
               if (!has_above && !moving_up)
                  dir_next = has_below ? DIR_DOWN : DIR_IDLE;
            end
            DIR_DOWN: begin
               if (!has_below && !moving_down)
                  dir_next = has_above ? DIR_UP : DIR_IDLE;
            end
            default: dir_next = DIR_IDLE;
         endcase
      end
   end

   // Target selection. While moving the target may only be pulled closer
   // in the direction of travel, so it never points behind the car. When
   // stopped it follows the next direction, which lets a fresh call reach
   // the target one cycle after it is latched.
   always_comb begin
      target_next = target_floor;
      if (floor_ok && !door_open) begin
         if (moving_up) begin
            if (has_above && (lowest_above < target_floor))
               target_next = lowest_above;
         end else if (moving_down) begin
            if (has_below && (highest_below > target_floor))
               target_next = highest_below;
         end else if ((dir_next == DIR_UP) && has_above) begin
            target_next = lowest_above;
         end else if ((dir_next == DIR_DOWN) && has_below) begin
            target_next = highest_below;
         end else begin
            target_next = cur_floor;
         end
      end
   end

   // State and registered outputs. Reset overrides everything, including a
   // reset arriving mid-move or with the door open.
   always_ff @(posedge clk) begin
      if (reset) begin
         door_q         <= 1'b0;
         door_qq        <= 1'b0;
         pending        <= '0;
         dir_q          <= DIR_IDLE;
         target_floor   <= '0;
         serviced       <= 1'b0;
         serviced_floor <= '0;
      end else begin
         door_q       <= door_open;
         door_qq      <= door_q;
         pending      <= (pending | call_req) & ~clear_mask;
         dir_q        <= dir_next;
         target_floor <= target_next;
         serviced     <= retire;
         if (retire)
            serviced_floor <= cur_floor;
      end
   end

   assign dir = dir_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler
// Directed bench for floor_request_scheduler: drives the control unit's
// floor/motion/door signals by hand and checks the scheduler's registered
// outputs against hand-computed values after each clock edge.
module tb_floor_request_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] call_req;
   logic [2:0] cur_floor;
   logic       moving_up;
   logic       moving_down;
   logic       door_open;
   logic [2:0] target_floor;
   logic [7:0] pending;
   logic [1:0] dir;
   logic       serviced;
   logic [2:0] serviced_floor;

   int total_checks = 0;
   int bad_checks   = 0;

   floor_request_scheduler #(
      .NUM_FLOORS(8),
      .FLOOR_BITS(3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .call_req       (call_req),
      .cur_floor      (cur_floor),
      .moving_up      (moving_up),
      .moving_down    (moving_down),
      .door_open      (door_open),
      .target_floor   (target_floor),
      .pending        (pending),
      .dir            (dir),
      .serviced       (serviced),
      .serviced_floor (serviced_floor)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Drive the control-unit view and buttons, then advance the given number
   // of rising edges; outputs are sampled 1 ns after the last edge.
   task automatic applyStimulus(input logic [7:0] calls, input logic [2:0] floor_in,
                                input logic up, input logic down, input logic door,
                                input int cycles);
      call_req    = calls;
      cur_floor   = floor_in;
      moving_up   = up;
      moving_down = down;
      door_open   = door;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total_checks++;
      assert (observed === expected) else begin
         bad_checks++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [2:0] exp_target,
                             input logic [1:0] exp_dir, input logic [7:0] exp_pending,
                             input logic exp_serviced);
      checkOutput({tag, ".target"},   32'(target_floor), 32'(exp_target));
      checkOutput({tag, ".dir"},      32'(dir),          32'(exp_dir));
      checkOutput({tag, ".pending"},  32'(pending),      32'(exp_pending));
      checkOutput({tag, ".serviced"}, 32'(serviced),     32'(exp_serviced));
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 2);
      reset = 1'b0;
      $display("[TB] reset and idle");
      checkState("reset", 3'd0, 2'b00, 8'h00, 1'b0);
      checkOutput("reset.sfloor", 32'(serviced_floor), 32'd0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1);
         checkState("idle", 3'd0, 2'b00, 8'h00, 1'b0);
      end

      $display("[TB] single call to floor 5, retired by door opening");
      applyStimulus(8'h20, 3'd0, 1'b0, 1'b0, 1'b0, 1);
      checkState("f5.latch", 3'd0, 2'b00, 8'h20, 1'b0);
      applyStimulus(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1);
      checkState("f5.target", 3'd5, 2'b01, 8'h20, 1'b0);
      applyStimulus(8'h00, 3'd5, 1'b0, 1'b0, 1'b1, 1);
      checkState("f5.doorrise", 3'd5, 2'b01, 8'h20, 1'b0);
      applyStimulus(8'h00, 3'd5, 1'b0, 1'b0, 1'b1, 1);
      checkState("f5.retire", 3'd5, 2'b01, 8'h00, 1'b1);
      checkOutput("f5.sfloor", 32'(serviced_floor), 32'd5);
      applyStimulus(8'h00, 3'd5, 1'b0, 1'b0, 1'b1, 1);
      checkState("f5.pulseend", 3'd5, 2'b01, 8'h00, 1'b0);
      applyStimulus(8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1);
      checkState("f5.idle", 3'd5, 2'b00, 8'h00, 1'b0);

      $display("[TB] moving up, closer call ahead");
      doReset();
      applyStimulus(8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1);
      checkState("up.start", 3'd1, 2'b00, 8'h00, 1'b0);
      applyStimulus(8'h40, 3'd1, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1);
      checkState("up.to6", 3'd6, 2'b01, 8'h40, 1'b0);
      applyStimulus(8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1);
      checkState("up.moving", 3'd6, 2'b01, 8'h40, 1'b0);
      applyStimulus(8'h10, 3'd2, 1'b1, 1'b0, 1'b0, 1);
      checkState("up.latch4", 3'd6, 2'b01, 8'h50, 1'b0);
      applyStimulus(8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1);
      checkState("up.to4", 3'd4, 2'b01, 8'h50, 1'b0);

      $display("[TB] moving up, call behind the car");
      doReset();
      applyStimulus(8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(8'h40, 3'd1, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1);
      applyStimulus(8'h02, 3'd2, 1'b1, 1'b0, 1'b0, 1);
      applyStimulus(8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1);
      checkState("behind", 3'd6, 2'b01, 8'h42, 1'b0);

      $display("[TB] distance tie from floor 3");
      doReset();
      applyStimulus(8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1);
      checkState("tie.start", 3'd3, 2'b00, 8'h00, 1'b0);
      applyStimulus(8'h22, 3'd3, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1);
      checkState("tie.up", 3'd5, 2'b01, 8'h22, 1'b0);
      applyStimulus(8'h00, 3'd5, 1'b0, 1'b0, 1'b1, 2);
      checkState("tie.retire5", 3'd5, 2'b01, 8'h02, 1'b1);
      checkOutput("tie.sfloor", 32'(serviced_floor), 32'd5);
      applyStimulus(8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1);
      checkState("tie.down", 3'd1, 2'b10, 8'h02, 1'b0);

      $display("[TB] call at the current stopped floor");
      doReset();
      applyStimulus(8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(8'h04, 3'd2, 1'b0, 1'b0, 1'b0, 1);
      checkState("here.latch", 3'd2, 2'b00, 8'h04, 1'b0);
      applyStimulus(8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1);
      checkState("here.retire", 3'd2, 2'b00, 8'h00, 1'b1);
      checkOutput("here.sfloor", 32'(serviced_floor), 32'd2);
      applyStimulus(8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1);
      checkState("here.after", 3'd2, 2'b00, 8'h00, 1'b0);

      $display("[TB] presses while the door opens, then reset");
      doReset();
      applyStimulus(8'h00, 3'd4, 1'b0, 1'b0, 1'b0, 1);
      checkState("door.start", 3'd4, 2'b00, 8'h00, 1'b0);
      applyStimulus(8'h00, 3'd4, 1'b0, 1'b0, 1'b1, 1);
      checkState("door.rise", 3'd4, 2'b00, 8'h00, 1'b0);
      applyStimulus(8'h90, 3'd4, 1'b0, 1'b0, 1'b1, 1);
      checkState("door.clearwins", 3'd4, 2'b00, 8'h80, 1'b1);
      checkOutput("door.sfloor", 32'(serviced_floor), 32'd4);
      applyStimulus(8'h00, 3'd4, 1'b0, 1'b0, 1'b1, 1);
      checkState("door.hold", 3'd4, 2'b00, 8'h80, 1'b0);
      reset = 1'b1;
      applyStimulus(8'h00, 3'd4, 1'b0, 1'b0, 1'b1, 1);
      reset = 1'b0;
      checkState("door.reset", 3'd0, 2'b00, 8'h00, 1'b0);
      checkOutput("door.reset.sfloor", 32'(serviced_floor), 32'd0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
